// File: rtl/r88_regfile.sv
// rtl/r88_regfile.sv - R88 register file: GPRs, DD/EE/PC/SP pointer pairs, address mux
//
// Purpose:
//   Byte-addressed register file for the R88 core. It holds NUM_GPR 8-bit
//   general registers (index 0 = A, 1 = B, 2 = C) followed by four 16-bit
//   pointers, each exposed as a low/high byte pair:
//     NUM_GPR+0/1 = DD, +2/3 = EE, +4/5 = PC, +6/7 = SP.
//   Two registered read ports use write-first bypass. A registered 16-bit
//   address output shows the pre-update value of {B,C}, DD, PC or SP.
//   PC has a dedicated incrementer and SP has push/pop. An explicit byte
//   write to a pointer always beats its increment/decrement.
//
// Configuration:
//   R88_REGFILE_SHADOW_EN - when defined, a second GPR bank exists and
//   bankSwap toggles bankSel. When undefined, there is no shadow storage,
//   bankSwap is ignored and bankSel is tied to 0.
//
// Ports:
//   sysClock        in   system clock, rising edge
//   sysResetN       in   asynchronous active-low reset
//   wrEn            in   write strobe
//   wrSel[SEL_W]    in   write register index
//   wrData[8]       in   write data
//   wr16            in   low-byte pointer write also loads wrHigh into high byte
//   wrHigh[8]       in   high byte for 16-bit writes
//   rdSelA/B[SEL_W] in   read port indices
//   rdDataA/B[8]    out  registered read data (1-cycle latency)
//   addrSel[2]      in   0={B,C} 1=DD 2=PC 3=SP
//   regAddr[16]     out  registered address output
//   pcInc           in   PC <= PC+1
//   spOp[2]         in   1=push (SP-1), 2=pop (SP+1), else none
//   bankSwap        in   toggle active GPR bank
//   bankSel         out  active GPR bank

module r88_regfile #(
  parameter int          NUM_GPR  = 3,
  parameter logic [15:0] PC_RESET = 16'hFFFE,
  parameter logic [15:0] SP_RESET = 16'hFFF9,
  localparam int         SEL_W    = $clog2(NUM_GPR + 8)
) (
  input  logic             sysClock,
  input  logic             sysResetN,
  input  logic             wrEn,
  input  logic [SEL_W-1:0] wrSel,
  input  logic [7:0]       wrData,
  input  logic             wr16,
  input  logic [7:0]       wrHigh,
  input  logic [SEL_W-1:0] rdSelA,
  input  logic [SEL_W-1:0] rdSelB,
  output logic [7:0]       rdDataA,
  output logic [7:0]       rdDataB,
  input  logic [1:0]       addrSel,
  output logic [15:0]      regAddr,
  input  logic             pcInc,
  input  logic [1:0]       spOp,
  input  logic             bankSwap,
  output logic             bankSel
);

  localparam int NSEL   = 1 << SEL_W;
  localparam int PTR_DD = 0;
  localparam int PTR_PC = 2;
  localparam int PTR_SP = 3;

  // Pointer storage: 0=DD, 1=EE, 2=PC, 3=SP
  logic [15:0] r_ptr [0:3];

  // GPR storage
`ifdef R88_REGFILE_SHADOW_EN
  logic [7:0]  r_gpr0 [0:NUM_GPR-1];
  logic [7:0]  r_gpr1 [0:NUM_GPR-1];
  logic        r_bank;
`else
  logic [7:0]  r_gpr  [0:NUM_GPR-1];
`endif

  logic [7:0]  w_gpr_cur [0:NUM_GPR-1];  // active-bank (pre-edge) GPR values
  logic        w_gpr_we  [0:NUM_GPR-1];
  logic        w_swap;

  logic        w_lo_we   [0:3];
  logic        w_hi_we   [0:3];
  logic [15:0] w_ptr_wr  [0:3];           // pointer value with only explicit writes applied
  logic [15:0] w_ptr_nxt [0:3];
  logic [7:0]  w_view    [0:NSEL-1];      // bypassed byte view used by both read ports
  logic [15:0] w_addr;

  // Bank selection
`ifdef R88_REGFILE_SHADOW_EN
  assign w_swap  = bankSwap;
  assign bankSel = r_bank;

  always_comb begin
    for (int g = 0; g < NUM_GPR; g++) begin
      w_gpr_cur[g] = r_bank ? r_gpr1[g] : r_gpr0[g];
    end
  end
`else
  logic w_unused_bankswap;
  assign w_unused_bankswap = bankSwap;
  assign w_swap  = 1'b0;
  assign bankSel = 1'b0;

  always_comb begin
    for (int g = 0; g < NUM_GPR; g++) begin
      w_gpr_cur[g] = r_gpr[g];
    end
  end
`endif

  // GPR write decode
  always_comb begin
    for (int g = 0; g < NUM_GPR; g++) begin
      w_gpr_we[g] = wrEn && (wrSel == SEL_W'(g));
    end
  end

  // Pointer byte write decode. A wr16 write to a low-byte index also
  // loads wrHigh into the paired high byte; a wr16 write to a high-byte
  // index behaves as a plain byte write.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_lo_we[k]  = wrEn && (wrSel == SEL_W'(NUM_GPR + 2*k));
      w_hi_we[k]  = wrEn && ((wrSel == SEL_W'(NUM_GPR + 2*k + 1)) ||
                             (wr16 && (wrSel == SEL_W'(NUM_GPR + 2*k))));
      w_ptr_wr[k] = r_ptr[k];
      if (w_lo_we[k]) begin
        w_ptr_wr[k][7:0] = wrData;
      end
      if (w_hi_we[k]) begin
        w_ptr_wr[k][15:8] = w_lo_we[k] ? wrHigh : wrData;
      end
    end
  end

  // Pointer next state: any explicit byte write suppresses inc/dec so the
  // untouched byte keeps its old value.
  always_comb begin
    w_ptr_nxt[0] = w_ptr_wr[0];
    w_ptr_nxt[1] = w_ptr_wr[1];

    if (w_lo_we[PTR_PC] || w_hi_we[PTR_PC]) begin
      w_ptr_nxt[PTR_PC] = w_ptr_wr[PTR_PC];
    end else if (pcInc) begin
      w_ptr_nxt[PTR_PC] = r_ptr[PTR_PC] + 16'd1;
    end else begin
      w_ptr_nxt[PTR_PC] = r_ptr[PTR_PC];
    end

    if (w_lo_we[PTR_SP] || w_hi_we[PTR_SP]) begin
      w_ptr_nxt[PTR_SP] = w_ptr_wr[PTR_SP];
    end else begin
      case (spOp)
        2'd1:    w_ptr_nxt[PTR_SP] = r_ptr[PTR_SP] - 16'd1;
        2'd2:    w_ptr_nxt[PTR_SP] = r_ptr[PTR_SP] + 16'd1;
        default: w_ptr_nxt[PTR_SP] = r_ptr[PTR_SP];
      endcase
    end
  end

  // Read view with write-first bypass. Pointer bytes show explicit writes
  // but never inc/dec results. During a bank swap the write targets the
  // other bank, so GPR reads must not be bypassed that cycle.
  always_comb begin
    for (int i = 0; i < NSEL; i++) begin
      w_view[i] = 8'h00;
    end
    for (int g = 0; g < NUM_GPR; g++) begin
      w_view[g] = (w_gpr_we[g] && !w_swap) ? wrData : w_gpr_cur[g];
    end
    for (int k = 0; k < 4; k++) begin
      w_view[NUM_GPR + 2*k]     = w_ptr_wr[k][7:0];
      w_view[NUM_GPR + 2*k + 1] = w_ptr_wr[k][15:8];
    end
  end

  // Address source uses pre-update state only
  always_comb begin
    case (addrSel)
      2'd0:    w_addr = {w_gpr_cur[1], w_gpr_cur[2]};
      2'd1:    w_addr = r_ptr[PTR_DD];
      2'd2:    w_addr = r_ptr[PTR_PC];
      default: w_addr = r_ptr[PTR_SP];
    endcase
  end

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      for (int g = 0; g < NUM_GPR; g++) begin
`ifdef R88_REGFILE_SHADOW_EN
        r_gpr0[g] <= 8'h00;
        r_gpr1[g] <= 8'h00;
`else
        r_gpr[g]  <= 8'h00;
`endif
      end
`ifdef R88_REGFILE_SHADOW_EN
      r_bank <= 1'b0;
`endif
      r_ptr[0]      <= 16'h0000;
      r_ptr[1]      <= 16'h0000;
      r_ptr[PTR_PC] <= PC_RESET;
      r_ptr[PTR_SP] <= SP_RESET;
      rdDataA       <= 8'h00;
      rdDataB       <= 8'h00;
      regAddr       <= 16'h0000;
    end else begin
`ifdef R88_REGFILE_SHADOW_EN
      if (bankSwap) begin
        r_bank <= ~r_bank;
      end
      // A write in a swap cycle lands in the bank active after the edge
      for (int g = 0; g < NUM_GPR; g++) begin
        if (w_gpr_we[g]) begin
          if (r_bank ^ bankSwap) begin
            r_gpr1[g] <= wrData;
          end else begin
            r_gpr0[g] <= wrData;
          end
        end
      end
`else
      for (int g = 0; g < NUM_GPR; g++) begin
        if (w_gpr_we[g]) begin
          r_gpr[g] <= wrData;
        end
      end
`endif
      for (int k = 0; k < 4; k++) begin
        r_ptr[k] <= w_ptr_nxt[k];
      end
      rdDataA <= w_view[rdSelA];
      rdDataB <= w_view[rdSelB];
      regAddr <= w_addr;
    end
  end

endmodule

// File: tb/tb_r88_regfile.sv
// tb/tb_r88_regfile.sv - directed scoreboard bench for r88_regfile
module tb_r88_regfile;

  logic        sysClock = 1'b0;
  logic        sysResetN;
  logic        wrEn;
  logic [3:0]  wrSel;
  logic [7:0]  wrData;
  logic        wr16;
  logic [7:0]  wrHigh;
  logic [3:0]  rdSelA;
  logic [3:0]  rdSelB;
  logic [7:0]  rdDataA;
  logic [7:0]  rdDataB;
  logic [1:0]  addrSel;
  logic [15:0] regAddr;
  logic        pcInc;
  logic [1:0]  spOp;
  logic        bankSwap;
  logic        bankSel;

  r88_regfile dut (
    .sysClock  (sysClock),
    .sysResetN (sysResetN),
    .wrEn      (wrEn),
    .wrSel     (wrSel),
    .wrData    (wrData),
    .wr16      (wr16),
    .wrHigh    (wrHigh),
    .rdSelA    (rdSelA),
    .rdSelB    (rdSelB),
    .rdDataA   (rdDataA),
    .rdDataB   (rdDataB),
    .addrSel   (addrSel),
    .regAddr   (regAddr),
    .pcInc     (pcInc),
    .spOp      (spOp),
    .bankSwap  (bankSwap),
    .bankSel   (bankSel)
  );

  always #5 sysClock = ~sysClock;

  localparam int K_RDA = 0;
  localparam int K_RDB = 1;
  localparam int K_ADR = 2;
  localparam int K_BNK = 3;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       tag;
  } chk_t;

  chk_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic push(input int kind, input logic [15:0] v, input string tag);
    chk_t c;
    c.kind = kind;
    c.exp  = v;
    c.tag  = tag;
    sb.push_back(c);
  endtask

  task automatic drain();
    chk_t        c;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.kind)
        K_RDA:   obs = {8'h00, rdDataA};
        K_RDB:   obs = {8'h00, rdDataB};
        K_ADR:   obs = regAddr;
        default: obs = {15'h0000, bankSel};
      endcase
      n_vec++;
      assert (obs === c.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", c.tag, obs, c.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge sysClock);
    #1;
    drain();
  endtask

  task automatic idle();
    wrEn     = 1'b0;
    wr16     = 1'b0;
    pcInc    = 1'b0;
    spOp     = 2'd0;
    bankSwap = 1'b0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [7:0] d, input logic w16, input logic [7:0] hi);
    wrEn   = 1'b1;
    wrSel  = sel;
    wrData = d;
    wr16   = w16;
    wrHigh = hi;
  endtask

  initial begin
    sysResetN = 1'b0;
    idle();
    wrSel = 4'd0; wrData = 8'h00; wrHigh = 8'h00;
    rdSelA = 4'd0; rdSelB = 4'd0; addrSel = 2'd0;

    // Reset state
    repeat (2) @(posedge sysClock);
    #1;
    push(K_RDA, 16'h0000, "rst_rdA");
    push(K_RDB, 16'h0000, "rst_rdB");
    push(K_ADR, 16'h0000, "rst_addr");
    push(K_BNK, 16'h0000, "rst_bank");
    drain();
    #3 sysResetN = 1'b1;

    // PC / SP reset values
    addrSel = 2'd2; rdSelA = 4'd7; rdSelB = 4'd8;
    push(K_ADR, 16'hFFFE, "pc_reset_addr");
    push(K_RDA, 16'h00FE, "pc_lo_reset");
    push(K_RDB, 16'h00FF, "pc_hi_reset");
    tick();
    addrSel = 2'd3; rdSelA = 4'd9; rdSelB = 4'd10;
    push(K_ADR, 16'hFFF9, "sp_reset_addr");
    push(K_RDA, 16'h00F9, "sp_lo_reset");
    push(K_RDB, 16'h00FF, "sp_hi_reset");
    tick();

    // GPR write with same-cycle bypass
    wr(4'd0, 8'h5A, 1'b0, 8'h00); rdSelA = 4'd0; rdSelB = 4'd1;
    push(K_RDA, 16'h005A, "a_bypass");
    push(K_RDB, 16'h0000, "b_zero");
    tick();
    idle();
    push(K_RDA, 16'h005A, "a_held");
    tick();

    // {B,C} address source
    wr(4'd1, 8'h12, 1'b0, 8'h00);
    tick();
    wr(4'd2, 8'h34, 1'b0, 8'h00); rdSelB = 4'd2;
    push(K_RDB, 16'h0034, "c_bypass");
    tick();
    idle(); addrSel = 2'd0; rdSelA = 4'd1;
    push(K_ADR, 16'h1234, "addr_bc");
    push(K_RDA, 16'h0012, "b_read");
    tick();

    // Unmapped indices
    wr(4'd11, 8'h77, 1'b0, 8'h00); rdSelA = 4'd11; rdSelB = 4'd15;
    push(K_RDA, 16'h0000, "unmapped_rd11");
    push(K_RDB, 16'h0000, "unmapped_rd15");
    tick();
    idle(); rdSelA = 4'd0; rdSelB = 4'd1;
    push(K_RDA, 16'h005A, "unmapped_wr_a");
    push(K_RDB, 16'h0012, "unmapped_wr_b");
    tick();

    // wr16 into DD with high-byte bypass
    wr(4'd3, 8'hCD, 1'b1, 8'hAB); rdSelA = 4'd3; rdSelB = 4'd4; addrSel = 2'd1;
    push(K_RDA, 16'h00CD, "dd_lo_bypass");
    push(K_RDB, 16'h00AB, "dd_hi_bypass");
    push(K_ADR, 16'h0000, "dd_addr_pre");
    tick();
    idle();
    push(K_ADR, 16'hABCD, "dd_addr");
    tick();

    // wr16 on a high-byte index writes only wrData
    wr(4'd4, 8'hEE, 1'b1, 8'h99); rdSelA = 4'd4; rdSelB = 4'd5;
    push(K_RDA, 16'h00EE, "dd_hi_w16");
    push(K_RDB, 16'h0000, "ee_lo_untouched");
    tick();
    idle(); rdSelB = 4'd6;
    push(K_ADR, 16'hEECD, "dd_addr_hiw16");
    push(K_RDB, 16'h0000, "ee_hi_untouched");
    tick();

    // wr16 on a GPR index writes only wrData
    wr(4'd0, 8'h66, 1'b1, 8'h99); rdSelA = 4'd0; rdSelB = 4'd1;
    push(K_RDA, 16'h0066, "gpr_w16_a");
    push(K_RDB, 16'h0012, "gpr_w16_b_byp");
    tick();
    idle();
    push(K_RDA, 16'h0066, "gpr_w16_a_held");
    push(K_RDB, 16'h0012, "gpr_w16_b_held");
    tick();

    // PC wrap and write priority over pcInc
    wr(4'd7, 8'hFF, 1'b1, 8'hFF);
    tick();
    idle(); pcInc = 1'b1; addrSel = 2'd2; rdSelA = 4'd7; rdSelB = 4'd8;
    push(K_ADR, 16'hFFFF, "pc_pre_inc");
    push(K_RDA, 16'h00FF, "pc_lo_pre_inc");
    push(K_RDB, 16'h00FF, "pc_hi_pre_inc");
    tick();
    idle();
    push(K_ADR, 16'h0000, "pc_wrap");
    push(K_RDA, 16'h0000, "pc_lo_wrap");
    push(K_RDB, 16'h0000, "pc_hi_wrap");
    tick();
    pcInc = 1'b1; wr(4'd7, 8'h10, 1'b0, 8'h00);
    push(K_RDA, 16'h0010, "pc_wr_bypass");
    push(K_ADR, 16'h0000, "pc_wr_addr_pre");
    tick();
    idle();
    push(K_ADR, 16'h0010, "pc_wr_no_inc");
    tick();

    // SP push/pop wrap
    wr(4'd9, 8'h00, 1'b1, 8'h00);
    tick();
    idle(); spOp = 2'd1; addrSel = 2'd3; rdSelA = 4'd9; rdSelB = 4'd10;
    push(K_ADR, 16'h0000, "sp_push_pre");
    push(K_RDA, 16'h0000, "sp_lo_push_pre");
    tick();
    spOp = 2'd2;
    push(K_ADR, 16'hFFFF, "sp_push_wrap");
    push(K_RDB, 16'h00FF, "sp_hi_push_wrap");
    tick();
    idle();
    push(K_ADR, 16'h0000, "sp_pop_wrap");
    tick();

    // pcInc, push and unrelated write together
    pcInc = 1'b1; spOp = 2'd1; wr(4'd0, 8'h77, 1'b0, 8'h00); addrSel = 2'd2; rdSelA = 4'd0;
    push(K_ADR, 16'h0010, "combo_pc_pre");
    push(K_RDA, 16'h0077, "combo_a_bypass");
    tick();
    idle(); addrSel = 2'd3;
    push(K_ADR, 16'hFFFF, "combo_sp");
    push(K_RDA, 16'h0077, "combo_a");
    tick();
    addrSel = 2'd2;
    push(K_ADR, 16'h0011, "combo_pc");
    tick();

    // SP write beats push; other byte kept
    spOp = 2'd1; wr(4'd10, 8'h12, 1'b0, 8'h00); addrSel = 2'd3; rdSelB = 4'd10;
    push(K_RDB, 16'h0012, "sp_hi_bypass");
    push(K_ADR, 16'hFFFF, "sp_wr_pre");
    tick();
    idle();
    push(K_ADR, 16'h12FF, "sp_wr_no_dec");
    tick();

`ifdef R88_REGFILE_SHADOW_EN
    wr(4'd0, 8'h11, 1'b0, 8'h00); rdSelA = 4'd0;
    tick();
    bankSwap = 1'b1; wr(4'd0, 8'h22, 1'b0, 8'h00);
    push(K_RDA, 16'h0011, "swap_rd_old_bank");
    push(K_BNK, 16'h0001, "swap_bank1");
    tick();
    idle(); addrSel = 2'd0;
    push(K_RDA, 16'h0022, "bank1_a");
    push(K_BNK, 16'h0001, "bank1_held");
    push(K_ADR, 16'h0000, "bank1_bc");
    tick();
    bankSwap = 1'b1;
    push(K_RDA, 16'h0022, "swap2_rd");
    push(K_BNK, 16'h0000, "swap_bank0");
    tick();
    idle();
    push(K_RDA, 16'h0011, "bank0_a");
    push(K_ADR, 16'h1234, "bank0_bc");
    tick();
`else
    bankSwap = 1'b1; wr(4'd0, 8'h22, 1'b0, 8'h00); rdSelA = 4'd0;
    push(K_RDA, 16'h0022, "noshadow_bypass");
    push(K_BNK, 16'h0000, "noshadow_bank");
    tick();
    idle(); bankSwap = 1'b1;
    push(K_RDA, 16'h0022, "noshadow_a");
    push(K_BNK, 16'h0000, "noshadow_bank2");
    tick();
    idle();
`endif

    // Reset mid-operation while pcInc active
    wr(4'd7, 8'h34, 1'b1, 8'h12);
    tick();
    idle(); pcInc = 1'b1; addrSel = 2'd2; rdSelA = 4'd7;
    push(K_ADR, 16'h1234, "pc_1234");
    push(K_RDA, 16'h0034, "pc_lo_1234");
    tick();
    #2 sysResetN = 1'b0;
    #1;
    push(K_ADR, 16'h0000, "midrst_addr");
    push(K_RDA, 16'h0000, "midrst_rdA");
    push(K_RDB, 16'h0000, "midrst_rdB");
    push(K_BNK, 16'h0000, "midrst_bank");
    drain();
    idle();
    #2 sysResetN = 1'b1;
    wr(4'd0, 8'h42, 1'b0, 8'h00); rdSelA = 4'd0; rdSelB = 4'd1; addrSel = 2'd2;
    push(K_RDA, 16'h0042, "post_rst_write");
    push(K_RDB, 16'h0000, "post_rst_b");
    push(K_ADR, 16'hFFFE, "post_rst_pc");
    tick();
    idle(); rdSelA = 4'd7; addrSel = 2'd3;
    push(K_RDA, 16'h00FE, "post_rst_pc_lo");
    push(K_ADR, 16'hFFF9, "post_rst_sp");
    tick();
    rdSelA = 4'd3;
    push(K_RDA, 16'h0000, "post_rst_dd");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
